// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: frequency setpoint controller for the DDS tuning input.
// Manual mode walks a fine range and then a coarse preset ladder with up/down keys.
// Learn mode saves the setpoint, sweeps from LEARN_START and restores the saved value on exit.
// Optional macro AUTO_SWEEP_EN adds a dwell timer that steps the learn sweep on its own.
module freq_sweep_ctrl #(
    parameter int FREQ_W      = 16,
    parameter int FREQ_MIN    = 1,
    parameter int FINE_MAX    = 30,
    parameter int COARSE_STEP = 15000,
    parameter int FREQ_MAX    = 45000,
    parameter int LEARN_START = 4,
    parameter int LEARN_STEP  = 1,
    parameter int LEARN_STOP  = 100,
    parameter int DWELL_CYC   = 50000
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [1:0]        key,
    input  logic              learn_en,
    input  logic              next_freq,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_upd,
    output logic              learn_busy,
    output logic              sweep_done
);

    typedef enum logic [1:0] {NORM = 2'd0, LEARN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_FINE  = FREQ_W'(FINE_MAX);
    localparam logic [FREQ_W-1:0] F_CSTEP = FREQ_W'(COARSE_STEP);
    localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] F_START = FREQ_W'(LEARN_START);
    localparam logic [FREQ_W-1:0] F_STOP  = FREQ_W'(LEARN_STOP);
    localparam logic [FREQ_W:0]   L_STEP  = (FREQ_W+1)'(LEARN_STEP);
    localparam logic [FREQ_W:0]   L_STOP  = (FREQ_W+1)'(LEARN_STOP);

    state_t            state, state_nxt;
    logic [FREQ_W-1:0] saved, saved_nxt, freq_nxt;
    logic              upd_force;
    logic [1:0]        key_s1, key_s2, key_s3;
    logic              le_s1, le_s2;
    logic              nf_s1, nf_s2, nf_s3;
    logic              dn_evt, up_evt, step_req, step_evt;
    logic              on_fine, on_ladder;
    logic [FREQ_W:0]   sum;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            key_s3 <= 2'b11;
            le_s1  <= 1'b0;
            le_s2  <= 1'b0;
            nf_s1  <= 1'b0;
            nf_s2  <= 1'b0;
            nf_s3  <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            le_s1  <= learn_en;
            le_s2  <= le_s1;
            nf_s1  <= next_freq;
            nf_s2  <= nf_s1;
            nf_s3  <= nf_s2;
        end
    end

    // Keys are active low, so a press is a falling edge
    assign dn_evt   = key_s3[0] & ~key_s2[0];
    assign up_evt   = key_s3[1] & ~key_s2[1];
    assign step_req = nf_s2 & ~nf_s3;

    assign on_fine   = (freq_out >= F_MIN) && (freq_out <= F_FINE);
    assign on_ladder = (freq_out >= F_CSTEP) && (freq_out <= F_MAX) &&
                       ((freq_out % F_CSTEP) == '0);
    assign sum       = {1'b0, freq_out} + L_STEP;

`ifdef AUTO_SWEEP_EN
    localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    logic [CNT_W-1:0] dwell_cnt;
    logic             auto_step;

    assign auto_step = (state == LEARN) && (dwell_cnt == CNT_W'(DWELL_CYC - 1));
    assign step_evt  = step_req | auto_step;

    // Dwell timer: runs only while sweeping, restarts on entry and after every step
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)
            dwell_cnt <= '0;
        else if (state == LEARN && !step_evt)
            dwell_cnt <= dwell_cnt + 1'b1;
        else
            dwell_cnt <= '0;
    end
`else
    logic unused_dwell;
    assign unused_dwell = (DWELL_CYC == 0);
    assign step_evt     = step_req;
`endif

    // Next-state and next-setpoint decode
    always_comb begin
        state_nxt = state;
        freq_nxt  = freq_out;
        saved_nxt = saved;
        upd_force = 1'b0;
        case (state)
            NORM: begin
                if (le_s2) begin
                    // learn entry takes priority over any key press this cycle
                    state_nxt = LEARN;
                    saved_nxt = freq_out;
                    freq_nxt  = F_START;
                    upd_force = 1'b1;
                end else if (dn_evt) begin
                    if (freq_out == F_MIN)       freq_nxt = F_FINE;
                    else if (on_fine)            freq_nxt = freq_out - 1'b1;
                    else if (freq_out == F_CSTEP) freq_nxt = F_FINE;
                    else if (on_ladder)          freq_nxt = freq_out - F_CSTEP;
                    else                         freq_nxt = F_FINE;
                end else if (up_evt) begin
                    if (on_fine && freq_out != F_FINE) freq_nxt = freq_out + 1'b1;
                    else if (freq_out == F_FINE)       freq_nxt = F_CSTEP;
                    else if (on_ladder && freq_out != F_MAX) freq_nxt = freq_out + F_CSTEP;
                    else if (on_ladder)                freq_nxt = freq_out;
                    else                               freq_nxt = F_FINE;
                end
            end
            LEARN: begin
                if (!le_s2) begin
                    state_nxt = NORM;
                    freq_nxt  = saved;
                end else if (step_evt) begin
                    if (sum >= L_STOP) begin
                        freq_nxt  = F_STOP;
                        state_nxt = DONE;
                    end else begin
                        freq_nxt = sum[FREQ_W-1:0];
                    end
                end
            end
            DONE: begin
                if (!le_s2) begin
                    state_nxt = NORM;
                    freq_nxt  = saved;
                end
            end
            default: begin
                state_nxt = NORM;
                freq_nxt  = F_MIN;
            end
        endcase
    end

    // State, setpoint and update-pulse registers
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state    <= NORM;
            freq_out <= F_MIN;
            saved    <= '0;
            freq_upd <= 1'b0;
        end else begin
            state    <= state_nxt;
            freq_out <= freq_nxt;
            saved    <= saved_nxt;
            freq_upd <= upd_force | (freq_nxt != freq_out);
        end
    end

    assign learn_busy = (state == LEARN) || (state == DONE);
    assign sweep_done = (state == DONE);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Testbench for freq_sweep_ctrl: vector table for manual keys, hand sequences for
// learn corners, and a randomized run against a transaction-level reference model.
module tb_freq_sweep_ctrl;

`ifdef AUTO_SWEEP_EN
    localparam int TB_DWELL = 8;
`else
    localparam int TB_DWELL = 50000;
`endif

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  key = 2'b11;
    logic        learn_en = 1'b0;
    logic        next_freq = 1'b0;
    logic [15:0] freq_out;
    logic        freq_upd, learn_busy, sweep_done;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    freq_sweep_ctrl #(.DWELL_CYC(TB_DWELL)) dut (
        .clk_50m(clk_50m), .rst(rst), .key(key), .learn_en(learn_en),
        .next_freq(next_freq), .freq_out(freq_out), .freq_upd(freq_upd),
        .learn_busy(learn_busy), .sweep_done(sweep_done)
    );

    always #10 clk_50m = ~clk_50m;

    // count update pulses away from the active edge
    always @(negedge clk_50m) if (!rst && freq_upd === 1'b1) pulses++;

    typedef struct {
        logic [1:0]  press;   // bit0 = down, bit1 = up
        logic [15:0] exp_f;
        int          exp_p;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; key = 2'b11; learn_en = 1'b0; next_freq = 1'b0;
        tick(2);
        check("rst_freq", freq_out, 1);
        check("rst_upd", freq_upd, 0);
        check("rst_busy", learn_busy, 0);
        check("rst_done", sweep_done, 0);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press(input logic [1:0] p);
        key = ~p;
        tick(4);
        key = 2'b11;
        tick(4);
    endtask

    task automatic step_edge();
        next_freq = 1'b1;
        tick(3);
        next_freq = 1'b0;
        tick(3);
    endtask

    // reference model: spec rules as plain arithmetic on the setpoint value
    function automatic int m_on_ladder(input int f);
        return (f >= 15000 && f <= 45000 && f % 15000 == 0) ? 1 : 0;
    endfunction
    function automatic int m_up(input int f);
        if (f >= 1 && f < 30) return f + 1;
        if (f == 30) return 15000;
        if (m_on_ladder(f) != 0) return (f < 45000) ? f + 15000 : f;
        return 30;
    endfunction
    function automatic int m_down(input int f);
        if (f == 1) return 30;
        if (f > 1 && f <= 30) return f - 1;
        if (m_on_ladder(f) != 0) return (f == 15000) ? 30 : f - 15000;
        return 30;
    endfunction

    initial begin
        int p0, cur, lf, k, ep, r;
        bit seen;

        // manual-mode vector table, starting from reset value 1
        vecs.push_back('{2'b01, 16'd30, 1});
        vecs.push_back('{2'b10, 16'd15000, 1});
        vecs.push_back('{2'b10, 16'd30000, 1});
        vecs.push_back('{2'b10, 16'd45000, 1});
        vecs.push_back('{2'b10, 16'd45000, 0});
        vecs.push_back('{2'b01, 16'd30000, 1});
        vecs.push_back('{2'b01, 16'd15000, 1});
        vecs.push_back('{2'b01, 16'd30, 1});
        for (int v = 29; v >= 20; v--) vecs.push_back('{2'b01, 16'(v), 1});
        vecs.push_back('{2'b11, 16'd19, 1});
        vecs.push_back('{2'b10, 16'd20, 1});

        // test 1: three up presses with latency check
        do_reset();
        for (int i = 0; i < 3; i++) begin
            key = 2'b01;
            tick(2);
            check("lat_early_freq", freq_out, 1 + i);
            check("lat_early_upd", freq_upd, 0);
            tick(1);
            check("lat_freq", freq_out, 2 + i);
            check("lat_upd", freq_upd, 1);
            tick(1);
            check("lat_upd_clr", freq_upd, 0);
            key = 2'b11;
            tick(4);
        end

        // tests 2/3: table
        do_reset();
        foreach (vecs[i]) begin
            p0 = pulses;
            press(vecs[i].press);
            check($sformatf("vec%0d_freq", i), freq_out, vecs[i].exp_f);
            check($sformatf("vec%0d_pulse", i), pulses - p0, vecs[i].exp_p);
        end

`ifndef AUTO_SWEEP_EN
        // test 4: full sweep from saved 15000
        do_reset();
        press(2'b01); press(2'b10);
        check("t4_pre", freq_out, 15000);
        p0 = pulses;
        learn_en = 1'b1;
        tick(6);
        check("t4_entry", freq_out, 4);
        check("t4_busy", learn_busy, 1);
        check("t4_entry_pulse", pulses - p0, 1);
        for (int i = 0; i < 5; i++) step_edge();
        check("t4_mid", freq_out, 9);
        for (int i = 0; i < 91; i++) step_edge();
        check("t4_top", freq_out, 100);
        check("t4_done", sweep_done, 1);
        p0 = pulses;
        step_edge();
        check("t4_hold", freq_out, 100);
        check("t4_hold_pulse", pulses - p0, 0);
        tick(20);
        check("t4_no_auto", freq_out, 100);
        p0 = pulses;
        learn_en = 1'b0;
        tick(6);
        check("t4_restore", freq_out, 15000);
        check("t4_restore_pulse", pulses - p0, 1);
        check("t4_busy_clr", learn_busy, 0);
        check("t4_done_clr", sweep_done, 0);

        // test 5: exit coincident with step edge
        do_reset();
        learn_en = 1'b1; tick(6);
        for (int i = 0; i < 6; i++) step_edge();
        check("t5_at10", freq_out, 10);
        learn_en = 1'b0; next_freq = 1'b1;
        tick(4);
        check("t5_restore", freq_out, 1);
        check("t5_busy", learn_busy, 0);
        next_freq = 1'b0; tick(6);
        check("t5_settled", freq_out, 1);

        // learn entry beats a same-cycle key; keys ignored while learning
        learn_en = 1'b1; key = 2'b01;
        tick(4);
        key = 2'b11; tick(4);
        check("entry_wins", freq_out, 4);
        p0 = pulses;
        press(2'b10); press(2'b01);
        check("keys_ignored", freq_out, 4);
        check("keys_ignored_pulse", pulses - p0, 0);

        // asynchronous reset mid-sweep
        step_edge(); step_edge();
        check("pre_rst", freq_out, 6);
        #3 rst = 1'b1;
        #1;
        check("async_rst_freq", freq_out, 1);
        check("async_rst_busy", learn_busy, 0);
        learn_en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
        check("post_rst_freq", freq_out, 1);

        // randomized run against the reference model
        do_reset();
        cur = 1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            p0 = pulses;
            if (r <= 7) begin
                logic [1:0] pk;
                pk = (r <= 3) ? 2'b10 : (r <= 6) ? 2'b01 : 2'b11;
                lf = (pk[0]) ? m_down(cur) : m_up(cur);
                ep = (lf != cur) ? 1 : 0;
                press(pk);
                cur = lf;
                check($sformatf("rnd%0d_freq", i), freq_out, cur);
                check($sformatf("rnd%0d_pulse", i), pulses - p0, ep);
            end else begin
                k  = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 8);
                lf = 4; ep = 1;
                learn_en = 1'b1; tick(6);
                for (int s = 0; s < k; s++) begin
                    if (lf < 100) begin lf = (lf + 1 > 100) ? 100 : lf + 1; ep++; end
                    step_edge();
                end
                check($sformatf("rnd%0d_learn", i), freq_out, lf);
                check($sformatf("rnd%0d_done", i), sweep_done, (lf == 100) ? 1 : 0);
                learn_en = 1'b0; tick(6);
                if (cur != lf) ep++;
                check($sformatf("rnd%0d_restore", i), freq_out, cur);
                check($sformatf("rnd%0d_lpulse", i), pulses - p0, ep);
            end
        end
`else
        // test 6: dwell timer steps every TB_DWELL cycles
        do_reset();
        learn_en = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick(1);
            if (freq_upd === 1'b1) seen = 1;
        end
        check("auto_entry_seen", seen, 1);
        check("auto_entry_freq", freq_out, 4);
        for (int j = 0; j < 3; j++) begin
            seen = 0; k = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick(1); k++;
                if (freq_upd === 1'b1) seen = 1;
            end
            check($sformatf("auto_gap%0d", j), k, TB_DWELL);
            check($sformatf("auto_freq%0d", j), freq_out, 5 + j);
        end
        #3 rst = 1'b1;
        #1;
        check("auto_async_rst", freq_out, 1);
        check("auto_rst_busy", learn_busy, 0);
        learn_en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        check("auto_idle", freq_out, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
